// File: rtl/regwrite_arbiter_pkg.sv
// Shared constants and decode helper for the register-array write port arbiter.
package regarb_pkg;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int N_REQ_MAX = 8;

  function automatic logic [REG_COUNT-1:0] onehot5to32(input logic [REG_IDX_W-1:0] idx);
    return REG_COUNT'(1) << idx;
  endfunction
endpackage

// File: rtl/regwrite_arbiter_if.sv
// Writeback request, reservation and register-array write bus shared by producers and the arbiter.
interface regwrite_arbiter_if
  import regarb_pkg::*;
#(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*REG_IDX_W-1:0] req_rd;
  logic [N_REQ*XLEN-1:0]      req_data;
  logic [N_REQ-1:0]           req_ready;
  logic                       hold;
  logic                       rsv_valid;
  logic [REG_IDX_W-1:0]       rsv_rd;
  logic [XLEN-1:0]            G;
  logic [REG_COUNT-1:0]       R_in;
  logic [REG_COUNT-1:0]       busy;

  modport master (
    output req_valid, req_rd, req_data, hold, rsv_valid, rsv_rd,
    input  req_ready, G, R_in, busy
  );

  modport slave (
    input  req_valid, req_rd, req_data, hold, rsv_valid, rsv_rd,
    output req_ready, G, R_in, busy
  );
endinterface

// File: rtl/regwrite_arbiter_rr_arbiter.sv
// Round-robin grant generator; defining REGARB_FIXED_PRIO_EN removes the pointer
// and gives index 0 the highest static priority.
module rr_arbiter #(
  parameter int N = 3
) (
`ifndef REGARB_FIXED_PRIO_EN
  input  logic         clk,
  input  logic         resetn,
`endif
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

`ifdef REGARB_FIXED_PRIO_EN
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  function automatic int wrap(input int a);
    return (a >= N) ? a - N : a;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    if (en) begin
      // Scan offsets ptr, ptr+1, ... so the requester just after the last winner goes first.
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < N; i++) begin
          if (!found && req[i] && (i == wrap(int'(ptr) + k))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_nxt  = (i == N - 1) ? '0 : PW'(i + 1);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) ptr <= '0;
    else         ptr <= ptr_nxt;
  end
`endif

endmodule

// File: rtl/regwrite_arbiter.sv
// Sole owner of the register-array write port: arbitrates writebacks, drives G/R_in one cycle
// later and tracks pending destinations in busy. REGARB_FIXED_PRIO_EN selects fixed priority.
module regwrite_arbiter
  import regarb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input logic               clk,
  input logic               resetn,
  regwrite_arbiter_if.slave bus
);

  logic [N_REQ-1:0]     grant;
  logic                 xfer;
  logic [REG_IDX_W-1:0] wr_rd;
  logic [XLEN-1:0]      wr_data;
  logic [REG_COUNT-1:0] clr_mask;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] wr_en;

  rr_arbiter #(.N(N_REQ)) u_arb (
`ifndef REGARB_FIXED_PRIO_EN
    .clk    (clk),
    .resetn (resetn),
`endif
    .en     (resetn && !bus.hold),
    .req    (bus.req_valid),
    .grant  (grant)
  );

  // The grant is only ever raised on a valid requester, so ready alone implies a transfer.
  assign bus.req_ready = grant;

  always_comb begin
    xfer    = |grant;
    wr_rd   = '0;
    wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        wr_rd   = bus.req_rd[i*REG_IDX_W +: REG_IDX_W];
        wr_data = bus.req_data[i*XLEN +: XLEN];
      end
    end
    clr_mask = xfer ? onehot5to32(wr_rd) : '0;
    set_mask = bus.rsv_valid ? onehot5to32(bus.rsv_rd) : '0;
    wr_en    = clr_mask;
    // Register 0 writes are accepted but never reach the array nor mark it pending.
    if (ZERO_REG_RO) begin
      wr_en[0]    = 1'b0;
      set_mask[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.G    <= '0;
      bus.R_in <= '0;
      bus.busy <= '0;
    end else begin
      bus.R_in <= wr_en;
      if (xfer) bus.G <= wr_data;
      // Set is applied after clear so a same-edge reserve of the written register wins.
      bus.busy <= (bus.busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: stimulus queues expected post-edge outputs,
// a monitor pops and compares them one cycle later.
module tb_regwrite_arbiter;
  import regarb_pkg::*;

  localparam int N = 3;
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'h2222_2222;
  localparam logic [31:0] D2 = 32'h3333_3333;

  typedef struct {
    logic [31:0] rin;
    logic [31:0] g;
    logic        gchk;
    logic [31:0] busy;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] busy_m;

  always #5 clk = ~clk;

  regwrite_arbiter_if #(.N_REQ(N)) bus ();

  regwrite_arbiter #(.N_REQ(N), .ZERO_REG_RO(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs are already driven; checks ready, queues the post-edge expectation, advances one cycle.
  task automatic step(input string name, input logic [N-1:0] exp_ready, input logic [31:0] exp_rin,
                      input logic [31:0] exp_g, input logic gchk, input logic [31:0] exp_busy);
    exp_t e;
    #1;
    check({name, " ready"}, 32'(bus.req_ready), 32'(exp_ready));
    e.rin  = exp_rin;
    e.g    = exp_g;
    e.gchk = gchk;
    e.busy = exp_busy;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, " R_in"}, bus.R_in, mon_e.rin);
        if (mon_e.gchk) check({mon_e.name, " G"}, bus.G, mon_e.g);
        check({mon_e.name, " busy"}, bus.busy, mon_e.busy);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    bus.req_valid = '1;
    bus.req_rd    = {5'd3, 5'd2, 5'd1};
    bus.req_data  = {D2, D1, D0};
    bus.hold      = 1'b0;
    bus.rsv_valid = 1'b0;
    bus.rsv_rd    = '0;
    step("reset", 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);

    resetn        = 1'b1;
    bus.req_valid = '0;
    step("idle", 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);

    bus.req_valid = '1;
`ifdef REGARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) step("fair", 3'b001, 32'h2, D0, 1'b1, 32'h0);
`else
    step("fair0", 3'b001, 32'h2, D0, 1'b1, 32'h0);
    step("fair1", 3'b010, 32'h4, D1, 1'b1, 32'h0);
    step("fair2", 3'b100, 32'h8, D2, 1'b1, 32'h0);
    step("fair3", 3'b001, 32'h2, D0, 1'b1, 32'h0);
    step("fair4", 3'b010, 32'h4, D1, 1'b1, 32'h0);
`endif

    bus.req_valid = 3'b001;
    bus.req_rd    = {5'd3, 5'd2, 5'd5};
    bus.req_data  = {D2, D1, 32'hDEAD_BEEF};
    step("single", 3'b001, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 32'h0);
    bus.req_valid = '0;
    step("single_after", 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);

    bus.req_valid = 3'b001;
    bus.req_rd    = {5'd3, 5'd2, 5'd0};
    bus.req_data  = {D2, D1, 32'h0000_1234};
    step("zero_reg", 3'b001, 32'h0, 32'h0, 1'b0, 32'h0);

    bus.req_valid = '0;
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd7;
    step("rsv7", 3'b000, 32'h0, 32'h0, 1'b0, 32'h80);

    bus.rsv_valid = 1'b0;
    bus.req_valid = 3'b001;
    bus.req_rd    = {5'd3, 5'd2, 5'd7};
    bus.req_data  = {D2, D1, 32'h0000_0077};
    step("wr7", 3'b001, 32'h80, 32'h77, 1'b1, 32'h0);

    bus.rsv_valid = 1'b1;
    step("rsv_wr7", 3'b001, 32'h80, 32'h77, 1'b1, 32'h80);

    // Hold begins while the rsv_wr7 pulse is still due; reserving r0 must not set busy[0].
    bus.hold      = 1'b1;
    bus.req_valid = '1;
    bus.req_rd    = {5'd3, 5'd2, 5'd1};
    bus.req_data  = {D2, D1, D0};
    bus.rsv_rd    = 5'd0;
    step("hold0", 3'b000, 32'h0, 32'h0, 1'b0, 32'h80);
    bus.rsv_rd    = 5'd3;
    step("hold1", 3'b000, 32'h0, 32'h0, 1'b0, 32'h88);
    bus.rsv_valid = 1'b0;
    step("hold2", 3'b000, 32'h0, 32'h0, 1'b0, 32'h88);

    bus.hold = 1'b0;
`ifdef REGARB_FIXED_PRIO_EN
    step("release", 3'b001, 32'h2, D0, 1'b1, 32'h88);
`else
    step("release", 3'b010, 32'h4, D1, 1'b1, 32'h88);
`endif

    bus.req_valid = '0;
    busy_m        = 32'h88;
    for (int k = 1; k <= 6; k++) begin
      bus.rsv_valid = 1'b1;
      bus.rsv_rd    = 5'(k);
      busy_m        = busy_m | (32'd1 << k);
      step("rsv_fill", 3'b000, 32'h0, 32'h0, 1'b0, busy_m);
    end

    bus.rsv_rd    = 5'd7;
    bus.req_valid = '1;
`ifdef REGARB_FIXED_PRIO_EN
    step("rsv_wr_mix", 3'b001, 32'h2, D0, 1'b1, 32'hFC);
`else
    step("rsv_wr_mix", 3'b100, 32'h8, D2, 1'b1, 32'hF6);
`endif

    resetn = 1'b0;
    step("mid_reset", 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);

    resetn        = 1'b1;
    bus.req_valid = '0;
    bus.rsv_valid = 1'b0;
    step("post_reset", 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Sole owner of the register array write port: drives the shared G bus and the one-hot R_in enable vector.
- Arbitrates writeback requests from N_REQ producers (ALU, load unit, CSR/misc) using round-robin.
- Keeps a pending-write scoreboard so issue logic can detect RAW/WAW hazards on destination registers.
- Sits between the execute/memory stages and the register array.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- ZERO_REG_RO, 1, when 1, writes to register 0 are accepted and discarded (R_in stays 0).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester writeback valid.
- req_rd  in  N_REQ*5  per-requester destination index; slice i is [5i+4:5i].
- req_data  in  N_REQ*32  per-requester write data; slice i is [32i+31:32i].
- req_ready  out  N_REQ  combinational grant/accept, one-hot or zero.
- hold  in  1  freezes arbitration: no grants while high.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_rd  in  5  index being reserved.
- G  out  32  registered write data to the register array.
- R_in  out  32  registered one-hot write enable to the register array.
- busy  out  32  scoreboard; bit k=1 means a write to register k is pending.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - resetn is synchronous and active-low.
  - While resetn=0 at a rising edge: G=0, R_in=0, busy=0, rr pointer ptr=0.
  - req_ready is forced to 0 while resetn=0.
- Arbitration (combinational):
  - Candidates are requesters with req_valid=1.
  - Grant the first candidate at index ptr, ptr+1, …, wrapping modulo N_REQ.
  - req_ready[g]=1 only for the granted index, and only when hold=0.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Pointer update: on a transfer by index g, ptr <= (g+1) mod N_REQ. Otherwise ptr is unchanged.
- Write port timing:
  - Transfer at edge t gives G=req_data[g] and R_in=1<<req_rd[g] during cycle t+1.
  - Latency is 1 cycle. Each accepted write produces exactly one single-cycle R_in pulse.
  - With no transfer, R_in=0 next cycle. G holds its last value (don't-care while R_in=0).
- Register 0 (ZERO_REG_RO=1) and req_rd=0:
  - The transfer is still accepted (ready asserted).
  - R_in=0 next cycle.
  - busy[0] is never set.
- Back-to-back: one write per cycle sustained. Requesters must hold valid, rd and data stable until accepted.
- Scoreboard update, at the same edge:
  - A transfer to rd clears busy[rd].
  - rsv_valid sets busy[rsv_rd].
  - If the same index is both set and cleared, the set wins (busy stays 1).
  - rsv_valid to an already-busy register leaves it 1; no counting is done.
- hold=1:
  - All req_ready=0; ptr is frozen.
  - The write already registered still completes its cycle-t+1 pulse.
  - Reservations still apply.
- Reset mid-operation: any pending registered write is dropped (R_in=0), and busy is cleared.

Optional Feature:
- Macro REGARB_FIXED_PRIO_EN.
- When defined: ptr is removed and index 0 always has highest priority, then 1, 2, and so on.
- When undefined (default): round-robin as above.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package regarb_pkg holds:
  - REG_COUNT=32, REG_IDX_W=5, XLEN=32;
  - the onehot5to32 decode function;
  - N_REQ_MAX=8.
- One sub-module, rr_arbiter (N, req -> grant, ptr state, fixed-priority mode under the macro), instantiated once.
- Scoreboard and output registers stay in the top module.

Test Plan:
- Reset: resetn=0 for 1 edge with req_valid=all-1 -> req_ready=0, R_in=0, G=0, busy=0.
- Single write: req_valid=001, req_rd[0]=5, req_data[0]=0xDEADBEEF -> req_ready=001 in the same cycle; next cycle R_in=0x00000020, G=0xDEADBEEF; the cycle after, R_in=0.
- Fairness: all valid continuously with rd=1,2,3 -> grant order 0,1,2,0,1 and R_in=0x2,0x4,0x8,0x2,0x4. With REGARB_FIXED_PRIO_EN defined -> always 0, R_in=0x2.
- Zero register: req_rd=0, data=0x1234 -> ready=1, next-cycle R_in=0x00000000, busy[0]=0.
- Scoreboard:
  - rsv_valid with rsv_rd=7 -> busy=0x80.
  - Later, write to rd=7 -> busy=0 after that edge.
  - Simultaneous reserve of 7 and write to 7 -> busy[7] stays 1.
- Hold/reset: hold=1 with all valid for 3 cycles -> ready=0, R_in=0, ptr unchanged.
- Mid-stream reset: resetn=0 while busy=0xFF and a write is registered -> next cycle R_in=0, busy=0.
